// File: rtl/gcd_pkg.sv
// Shared types and mux-select encodings for the 4-bit GCD controller and datapath.
package gcd_pkg;

  // Controller state encoding; CLEAR is the reset state.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } gcd_state_e;

  // A-register input mux selects.
  localparam logic [1:0] A_SEL_OPA  = 2'd0;
  localparam logic [1:0] A_SEL_B    = 2'd1;
  localparam logic [1:0] A_SEL_SUB  = 2'd2;
  localparam logic [1:0] A_SEL_ZERO = 2'd3;

  // B-register input mux selects.
  localparam logic B_SEL_OPB = 1'b0;
  localparam logic B_SEL_A   = 1'b1;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating iteration counter: synchronous clear has priority over increment,
// and the count sticks at all-ones instead of wrapping.
module gcd_iter_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Clear on a new job, otherwise count up until saturated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gcd_control.sv
// Sequencing FSM for the 4-bit GCD datapath. Runs Euclid's algorithm by
// repeated subtract/swap, with valid/ready handshakes for operand load and
// result delivery, and counts CALC cycles per job.
module gcd_control
  import gcd_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_val_i,
  output logic             req_rdy_o,
  output logic             resp_val_o,
  input  logic             resp_rdy_i,
  input  logic             b_zero_i,
  input  logic             a_lt_b_i,
  output logic [1:0]       a_mux_sel_o,
  output logic             b_mux_sel_o,
  output logic             a_en_o,
  output logic             b_en_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cycles_o
);

  gcd_state_e state;
  logic       cnt_clr;
  logic       cnt_inc;

  // State register: CLEAR while reset is held and for one cycle after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= CLEAR;
    end else begin
      case (state)
        CLEAR: state <= IDLE;
        IDLE:  if (req_val_i) state <= CALC;
        CALC:  if (!a_lt_b_i && b_zero_i) state <= DONE;
        DONE:  if (resp_rdy_i) state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

  // Output decode: handshakes from state only, datapath controls may also use status in CALC.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    req_rdy_o   = (state == IDLE);
    resp_val_o  = (state == DONE);
    busy_o      = (state != IDLE);
    a_mux_sel_o = A_SEL_OPA;
    b_mux_sel_o = B_SEL_OPB;
    a_en_o      = 1'b0;
    b_en_o      = 1'b0;
    case (state)
      CLEAR: begin
        a_mux_sel_o = A_SEL_ZERO;
        a_en_o      = 1'b1;
      end
      IDLE: begin
        if (req_val_i) begin
          a_en_o = 1'b1;
          b_en_o = 1'b1;
        end
      end
      CALC: begin
        if (a_lt_b_i) begin
          a_mux_sel_o = A_SEL_B;
          b_mux_sel_o = B_SEL_A;
          a_en_o      = 1'b1;
          b_en_o      = 1'b1;
        end else if (!b_zero_i) begin
          a_mux_sel_o = A_SEL_SUB;
          a_en_o      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counter is cleared on accept and counts every CALC cycle, including the last.
  assign cnt_clr = (state == IDLE) && req_val_i;
  assign cnt_inc = (state == CALC);

  gcd_iter_cnt #(
    .CNT_W(CNT_W)
  ) u_iter_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cycles_o)
  );

endmodule
